// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: frames SOF, cmd, LEN and payload into TX FIFO pushes, honouring tx_fifo_full.
// Define UART_PKT_CHECKSUM_EN to append a mod-256 checksum byte of CMD, LEN and payload.
module uart_tx_packetizer #(
   parameter int unsigned PAYLOAD_BYTES = 4,
   parameter logic [7:0]  SOF_BYTE      = 8'hAA
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [7:0]                 cmd,
   input  logic [PAYLOAD_BYTES*8-1:0] payload,
   input  logic                       tx_fifo_full,
   output logic                       push,
   output logic [7:0]                 tx_data,
   output logic                       busy,
   output logic                       done
);
   localparam logic [3:0] LAST = 4'(PAYLOAD_BYTES - 1);
   typedef enum logic [2:0] {
      IDLE, SOF, CMD, LEN, PAYLOAD,
`ifdef UART_PKT_CHECKSUM_EN
      CSUM,
`endif
      DONE
   } state_t;
   state_t                     state;
   logic [7:0]                 cmd_q;
   logic [PAYLOAD_BYTES*8-1:0] pl_q;
   logic [3:0]                 idx;
`ifdef UART_PKT_CHECKSUM_EN
   logic [7:0]                 acc;
`endif
   assign push = busy & ~tx_fifo_full;
   // payload register shifts left on each accepted byte, so the top byte is always the next one
   always_comb
      tx_data = state == SOF     ? SOF_BYTE :
                state == CMD     ? cmd_q :
                state == LEN     ? 8'(PAYLOAD_BYTES) :
                state == PAYLOAD ? pl_q[PAYLOAD_BYTES*8-1 -: 8] :
`ifdef UART_PKT_CHECKSUM_EN
                state == CSUM    ? acc :
`endif
                8'h00;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cmd_q <= '0;
         pl_q  <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
         acc   <= '0;
`endif
      end else if (state == IDLE) begin
         if (start) begin
            state <= SOF;
            cmd_q <= cmd;
            pl_q  <= payload;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
            acc   <= '0;
`endif
         end
      end else if (state == DONE) begin
         state <= IDLE;
         done  <= 1'b0;
      end else if (push) begin
`ifdef UART_PKT_CHECKSUM_EN
         if (state inside {CMD, LEN, PAYLOAD}) acc <= acc + tx_data;
`endif
         case (state)
            SOF: state <= CMD;
            CMD: state <= LEN;
            LEN: state <= PAYLOAD;
            PAYLOAD: begin
               pl_q <= pl_q << 8;
               idx  <= idx + 4'd1;
               if (idx == LAST) begin
`ifdef UART_PKT_CHECKSUM_EN
                  state <= CSUM;
`else
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
               end
            end
            default: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         endcase
      end
endmodule

// File: tb/tb_uart_tx_packetizer.sv
// tb_uart_tx_packetizer: scoreboard bench for framing, backpressure, ignored starts and reset.
`timescale 1ns/1ps
module tb_uart_tx_packetizer;
   localparam int P = 4;
`ifdef UART_PKT_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int NB = 3 + P + CS;
   logic           clk = 1'b0, reset = 1'b0, start = 1'b0, tx_fifo_full = 1'b0;
   logic [7:0]     cmd = '0;
   logic [P*8-1:0] payload = '0;
   logic           push, busy, done;
   logic [7:0]     tx_data;
   logic [7:0]     exp_q[$];
   logic [7:0]     exp_b;
   int             assertions = 0, failures = 0;
   uart_tx_packetizer #(.PAYLOAD_BYTES(P), .SOF_BYTE(8'hAA)) dut (
      .clk(clk), .reset(reset), .start(start), .cmd(cmd), .payload(payload),
      .tx_fifo_full(tx_fifo_full), .push(push), .tx_data(tx_data), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   // every pushed byte must be the next one the model expects
   initial forever begin
      @(negedge clk);
      if (reset && push) begin
         assertions++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_push: got tx_data=%h, required no push", tx_data);
         end else begin
            exp_b = exp_q.pop_front();
            if (tx_data !== exp_b) begin
               failures++;
               $display("FAIL tx_byte: got %h, required %h", tx_data, exp_b);
            end
         end
      end
   end
   task automatic add_frame(input logic [7:0] c, input logic [P*8-1:0] p);
      logic [7:0] s;
      s = c + 8'(P);
      exp_q.push_back(8'hAA);
      exp_q.push_back(c);
      exp_q.push_back(8'(P));
      for (int i = P - 1; i >= 0; i--) begin
         exp_q.push_back(p[i*8 +: 8]);
         s = s + p[i*8 +: 8];
      end
      if (CS == 1) exp_q.push_back(s);
   endtask
   task automatic pulse_start(input logic [7:0] c, input logic [P*8-1:0] p);
      start = 1'b1;
      cmd = c;
      payload = p;
      add_frame(c, p);
      @(posedge clk); #1;
      start = 1'b0;
      cmd = ~c;
      payload = ~p;
   endtask
   task automatic test_reset;
      #3;
      assertions++;
      if ({push, busy, done, tx_data} !== 11'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %b, required %b", {push, busy, done, tx_data}, 11'h0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      assertions++;
      if ({push, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL idle_after_reset: got %b, required 000", {push, busy, done});
      end
      @(posedge clk); #1;
   endtask
   task automatic test_nominal;
      logic [2:0] e;
      pulse_start(8'h10, 32'h01020304);
      for (int c = 1; c <= NB + 2; c++) begin
         e = {c <= NB, c <= NB, c == NB + 1};
         @(negedge clk);
         assertions++;
         if ({push, busy, done} !== e) begin
            failures++;
            $display("FAIL nominal cycle %0d: got push/busy/done=%b, required %b", c, {push, busy, done}, e);
         end
         @(posedge clk); #1;
      end
      assertions++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL nominal_bytes: got %0d bytes unpushed, required 0", exp_q.size());
      end
   endtask
   task automatic test_backpressure;
      logic [2:0] e;
      pulse_start(8'h10, 32'h01020304);
      for (int c = 1; c <= NB + 6; c++) begin
         tx_fifo_full = (c >= 2 && c <= 4) || c == 7;
         e = {c <= NB + 4 && !tx_fifo_full, c <= NB + 4, c == NB + 5};
         @(negedge clk);
         assertions++;
         if ({push, busy, done} !== e) begin
            failures++;
            $display("FAIL backpressure cycle %0d: got push/busy/done=%b, required %b", c, {push, busy, done}, e);
         end
         @(posedge clk); #1;
      end
      tx_fifo_full = 1'b0;
      assertions++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL backpressure_bytes: got %0d bytes unpushed, required 0", exp_q.size());
      end
   endtask
   task automatic test_checksum_wrap;
      pulse_start(8'hFF, 32'hFFFFFFFF);
      for (int c = 1; c <= NB + 2; c++) begin
         @(negedge clk);
         assertions++;
         if (done !== (c == NB + 1)) begin
            failures++;
            $display("FAIL wrap_done cycle %0d: got %b, required %b", c, done, c == NB + 1);
         end
         @(posedge clk); #1;
      end
      assertions++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL wrap_bytes: got %0d bytes unpushed, required 0", exp_q.size());
      end
   endtask
   task automatic test_start_while_busy;
      logic [2:0] e;
      logic       b;
      pulse_start(8'h10, 32'h01020304);
      for (int c = 1; c <= NB + 12; c++) begin
         start = c == 3 || c == 10;
         cmd = c == 3 ? 8'h55 : 8'h21;
         payload = c == 3 ? 32'hDEADBEEF : 32'h0BADF00D;
         if (c == 10) add_frame(8'h21, 32'h0BADF00D);
         b = c <= NB || (c >= 11 && c <= NB + 10);
         e = {b, b, c == NB + 1 || c == NB + 11};
         @(negedge clk);
         assertions++;
         if ({push, busy, done} !== e) begin
            failures++;
            $display("FAIL busy_start cycle %0d: got push/busy/done=%b, required %b", c, {push, busy, done}, e);
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      assertions++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL busy_start_bytes: got %0d bytes unpushed, required 0", exp_q.size());
      end
   endtask
   task automatic test_reset_mid_frame;
      logic [2:0] e;
      pulse_start(8'h33, 32'hA1B2C3D4);
      repeat (4) @(posedge clk);
      #1;
      assertions++;
      if ({push, busy, done} !== 3'b110) begin
         failures++;
         $display("FAIL mid_frame_active: got push/busy/done=%b, required 110", {push, busy, done});
      end
      reset = 1'b0;
      exp_q.delete();
      #1;
      assertions++;
      if ({push, busy, done, tx_data} !== 11'h0) begin
         failures++;
         $display("FAIL async_reset: got %b, required %b", {push, busy, done, tx_data}, 11'h0);
      end
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         assertions++;
         if ({push, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle cycle %0d: got %b, required 000", c, {push, busy, done});
         end
         @(posedge clk); #1;
      end
      pulse_start(8'h44, 32'h0A0B0C0D);
      for (int c = 1; c <= NB + 2; c++) begin
         e = {c <= NB, c <= NB, c == NB + 1};
         @(negedge clk);
         assertions++;
         if ({push, busy, done} !== e) begin
            failures++;
            $display("FAIL restart cycle %0d: got push/busy/done=%b, required %b", c, {push, busy, done}, e);
         end
         @(posedge clk); #1;
      end
      assertions++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL restart_bytes: got %0d bytes unpushed, required 0", exp_q.size());
      end
   endtask
   initial begin
      test_reset;
      test_nominal;
      test_backpressure;
      test_checksum_wrap;
      test_start_while_busy;
      test_reset_mid_frame;
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
